// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions.
// FSM encodings, oversampling constant and command codes.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;

  localparam logic [7:0] CMD_N = 8'h6E;
  localparam logic [7:0] CMD_M = 8'h6D;

  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator for the UART receiver.
// One tick every DIV clocks; clr realigns phase to a start edge.
module baud_tick_gen
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // free-running divider, restarted by clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST) & ~clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// Mid-bit sampling, glitch rejection, frame error reporting.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = uart_rx_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [2:0] r_vld;

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_tcnt;
  logic [3:0] w_tcnt_nx;
  logic [2:0] r_bit;
  logic [2:0] w_bit_nx;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nx;

  logic       w_tick;
  logic       w_fall;
  logic       w_clr;
  logic       w_stop_end;
  logic       w_done;
  logic       w_ferr;

  logic [7:0] r_data;
  logic       r_done;
  logic       r_busy;
  logic       r_ferr;

  // synchronizer, edge history and reset-validity marks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_vld   <= 3'b000;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= {r_vld[1:0], 1'b1};
    end
  end

  // edges only count once both samples come from the real line,
  // so the reset value of the flops cannot fake a start bit
  assign w_fall = r_vld[2] & r_prev & ~r_sync2;
  assign w_clr  = (r_state == IDLE) & w_fall;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tcnt  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_tcnt  <= w_tcnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
    end
  end

  // next-state and tick/bit counting
  always_comb begin
    w_state_nx = r_state;
    w_tcnt_nx  = r_tcnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nx = START;
          w_tcnt_nx  = 4'd0;
          w_bit_nx   = 3'd0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_tcnt == MID_TICK) begin
            w_tcnt_nx  = 4'd0;
            w_state_nx = r_sync2 ? IDLE : DATA;
          end else begin
            w_tcnt_nx = r_tcnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_tcnt == LAST_TICK) begin
            w_tcnt_nx  = 4'd0;
            w_shift_nx = {r_sync2, r_shift[7:1]};
            w_bit_nx   = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              w_state_nx = STOP;
            end
          end else begin
            w_tcnt_nx = r_tcnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_tcnt == LAST_TICK) begin
            w_tcnt_nx  = 4'd0;
            w_state_nx = IDLE;
          end else begin
            w_tcnt_nx = r_tcnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // stop-bit verdict decode
  always_comb begin
    w_stop_end = 1'b0;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
    if ((r_state == STOP) && w_tick && (r_tcnt == LAST_TICK)) begin
      w_stop_end = 1'b1;
    end
    w_done = w_stop_end & r_sync2;
    w_ferr = w_stop_end & ~r_sync2;
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= 8'h00;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_done;
      r_ferr <= w_ferr;
      r_busy <= (w_state_nx != IDLE);
      if (w_done) begin
        r_data <= r_shift;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Serial frames are generated here and results compared to a queue model.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam longint LAT_MIN = 1518;
  localparam longint LAT_MAX = 1528;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  logic [7:0] got_q[$];
  longint     done_cyc_q[$];
  longint     start_cyc_q[$];
  logic [7:0] sent_q[$];
  int done_hi = 0;
  int ferr_hi = 0;
  int both_hi = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_hi++;
      got_q.push_back(rx_data);
      done_cyc_q.push_back(cyc);
    end
    if (frame_err === 1'b1) ferr_hi++;
    if (rx_done === 1'b1 && frame_err === 1'b1) both_hi++;
  end

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    got_q.delete();
    done_cyc_q.delete();
    start_cyc_q.delete();
    sent_q.delete();
    done_hi = 0;
    ferr_hi = 0;
    both_hi = 0;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc_q.push_back(cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %0h expected 00", rx_data);
    end
    checks++;
    if (rx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %0b expected 0", rx_done);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b expected 0", rx_busy);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr: got %0b expected 0", frame_err);
    end
    rst = 1'b1;
    clear_mon();
    repeat (50) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || done_hi !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: busy %0b dones %0d expected 0 0",
               rx_busy, done_hi);
    end
  endtask

  task automatic test_single();
    clear_mon();
    sent_q.push_back(8'h6E);
    send_frame(8'h6E, 1'b1);
    drive_bit(1'b1);
    last_good = 8'h6E;
    checks++;
    if (done_hi !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d expected 1", done_hi);
    end
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 8'h6E) begin
      errors++;
      $display("FAIL single_data: got %0h expected 6e",
               (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    checks++;
    if (ferr_hi !== 0) begin
      errors++;
      $display("FAIL single_ferr: got %0d expected 0", ferr_hi);
    end
    checks++;
    if (done_cyc_q.size() < 1 ||
        done_cyc_q[0] - start_cyc_q[0] < LAT_MIN ||
        done_cyc_q[0] - start_cyc_q[0] > LAT_MAX) begin
      errors++;
      $display("FAIL single_latency: got %0d expected %0d..%0d",
               (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc_q[0] : -1,
               LAT_MIN, LAT_MAX);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [2];
    exp[0] = 8'h6D;
    exp[1] = 8'h6E;
    clear_mon();
    send_frame(exp[0], 1'b1);
    send_frame(exp[1], 1'b1);
    drive_bit(1'b1);
    last_good = exp[1];
    checks++;
    if (done_hi !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 2", done_hi);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_data%0d: got %0h expected %0h", i,
                 (got_q.size() > i) ? got_q[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (ferr_hi !== 0 || both_hi !== 0) begin
      errors++;
      $display("FAIL b2b_ferr: got %0d/%0d expected 0/0", ferr_hi, both_hi);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_rise: got %0b expected 1", rx_busy);
    end
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (65) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_drop: got %0b expected 0", rx_busy);
    end
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++;
    if (done_hi !== 0 || ferr_hi !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got done %0d ferr %0d expected 0 0",
               done_hi, ferr_hi);
    end
    checks++;
    if (rx_data !== last_good) begin
      errors++;
      $display("FAIL glitch_data: got %0h expected %0h", rx_data, last_good);
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'hA5, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    checks++;
    if (ferr_hi !== 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d expected 1", ferr_hi);
    end
    checks++;
    if (done_hi !== 0) begin
      errors++;
      $display("FAIL ferr_nodone: got %0d expected 0", done_hi);
    end
    checks++;
    if (rx_data !== last_good) begin
      errors++;
      $display("FAIL ferr_data_hold: got %0h expected %0h", rx_data, last_good);
    end
    send_frame(8'h6D, 1'b1);
    drive_bit(1'b1);
    last_good = 8'h6D;
    checks++;
    if (done_hi !== 1 || rx_data !== 8'h6D) begin
      errors++;
      $display("FAIL ferr_recover: got %0d/%0h expected 1/6d",
               done_hi, rx_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h6E;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rx_data !== 8'h00 || rx_busy !== 1'b0 ||
        rx_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got %0h/%0b/%0b/%0b expected 00/0/0/0",
               rx_data, rx_busy, rx_done, frame_err);
    end
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(d[i]);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    repeat (3 * BIT_CLKS) @(negedge clk);
    checks++;
    if (done_hi !== 0 || ferr_hi !== 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got done %0d ferr %0d busy %0b expected 0 0 0",
               done_hi, ferr_hi, rx_busy);
    end
    send_frame(8'h6D, 1'b1);
    drive_bit(1'b1);
    last_good = 8'h6D;
    checks++;
    if (done_hi !== 1 || got_q.size() < 1 || got_q[0] !== 8'h6D) begin
      errors++;
      $display("FAIL midrst_next: got %0d dones data %0h expected 1 6d",
               done_hi, rx_data);
    end
  endtask

  task automatic test_random();
    int gap;
    logic [7:0] b;
    clear_mon();
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      send_frame(b, 1'b1);
      gap = $urandom_range(0, 2 * BIT_CLKS);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    drive_bit(1'b1);
    last_good = sent_q[$];
    checks++;
    if (got_q.size() !== sent_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d expected %0d",
               got_q.size(), sent_q.size());
    end
    for (int i = 0; i < sent_q.size(); i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== sent_q[i]) begin
        errors++;
        $display("FAIL rand_data%0d: got %0h expected %0h", i,
                 (got_q.size() > i) ? got_q[i] : 8'hxx, sent_q[i]);
      end
      checks++;
      if (done_cyc_q.size() <= i ||
          done_cyc_q[i] - start_cyc_q[i] < LAT_MIN ||
          done_cyc_q[i] - start_cyc_q[i] > LAT_MAX) begin
        errors++;
        $display("FAIL rand_latency%0d: got %0d expected %0d..%0d", i,
                 (done_cyc_q.size() > i) ? done_cyc_q[i] - start_cyc_q[i] : -1,
                 LAT_MIN, LAT_MAX);
      end
    end
    checks++;
    if (ferr_hi !== 0 || both_hi !== 0 || done_hi !== sent_q.size()) begin
      errors++;
      $display("FAIL rand_pulses: got ferr %0d both %0d done_cycles %0d expected 0 0 %0d",
               ferr_hi, both_hi, done_hi, sent_q.size());
    end
    checks++;
    if (rx_data !== last_good) begin
      errors++;
      $display("FAIL rand_final: got %0h expected %0h", rx_data, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002: Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003: Parameter OVERSAMPLE, default 16, sample ticks per bit; fixed at 16, other values unsupported.
REQ-004: clk  input  1  system clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, asynchronous, active-low.
REQ-006: rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007: rx_data  output  8  last correctly framed byte; held until next good frame.
REQ-008: rx_done  output  1  one-clk pulse when rx_data updates; drives the switch selector's rx_done.
REQ-009: rx_busy  output  1  high from start-edge detection until return to IDLE.
REQ-010: frame_err  output  1  one-clk pulse when the stop bit samples low.

Function
REQ-011: rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (rx_s) only.
REQ-012: Tick divisor DIV SHALL be CLK_FREQ/(BAUD*16), integer truncated (651 at defaults); one tick every DIV clk cycles.
REQ-013: The tick counter SHALL clear on start-edge detection so ticks are phase-aligned to the frame.
REQ-014: FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015: IDLE: a falling edge on rx_s (previous 1, current 0) SHALL enter START with tick count 0; a low level alone SHALL NOT start a frame.
REQ-016: START: on tick 8, rx_s=0 SHALL enter DATA and rx_s=1 SHALL return to IDLE as a glitch, with no output pulse.
REQ-017: DATA: every 16th tick SHALL shift rx_s into bit position 0..7 (LSB first); after bit 7, enter STOP.
REQ-018: STOP: on the 16th tick, rx_s=1 SHALL load the shift register into rx_data, pulse rx_done for 1 clk and go IDLE.
REQ-019: STOP: on the 16th tick, rx_s=0 SHALL pulse frame_err for 1 clk, leave rx_data unchanged and go IDLE.
REQ-020: After a frame error, a new frame SHALL start only after rx_s returns high and then falls again (break-safe).
REQ-021: rx_done and frame_err SHALL never be high in the same cycle.
REQ-022: rx_done SHALL occur mid stop bit, about 9.5 bit times after the start edge plus 2 synchronizer clk.
REQ-023: A start edge arriving in the cycle after rx_done SHALL be accepted, so back-to-back frames are supported.
REQ-024: No output SHALL depend combinationally on rx.

Reset
REQ-025: With rst low, the block SHALL asynchronously clear rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0, FSM=IDLE, counters=0 and synchronizer flops=1.
REQ-026: Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, a new falling edge is required.

Structure
REQ-027: FSM state encodings and the OVERSAMPLE constant SHALL live in the shared UART definitions package/header, alongside the ASCII command codes "n"=8'h6E and "m"=8'h6D.
REQ-028: Tick generation SHALL be a sub-module baud_tick_gen (params CLK_FREQ, BAUD; ports clk, rst, clr, tick).
REQ-029: The RTL SHALL contain a single FSM always block plus output registers; target size 120-400 lines.

Verification
REQ-030: Bench SHALL override CLK_FREQ=1_600_000 and BAUD=10_000 (DIV=10) for speed.
REQ-031: Scenario: send 8'h6E framed -> exactly one rx_done pulse, rx_data=8'h6E, frame_err never high.
REQ-032: Scenario: send 8'h6D then 8'h6E with no idle gap -> two rx_done pulses, rx_data 8'h6D then 8'h6E.
REQ-033: Scenario: rx low for 3 ticks then high -> no rx_done, no frame_err, rx_busy drops to 0 by tick 9.
REQ-034: Scenario: 8'hA5 with stop bit driven low -> frame_err one pulse, rx_data keeps its prior value, no rx_done; then 8'h6D after rx high -> rx_done, rx_data=8'h6D.
REQ-035: Scenario: rst low during bit 4 of 8'h6E -> outputs reset at once; after release, the remainder of that frame produces no rx_done; the next full frame 8'h6D is received correctly.
